fclass_arbiter: RTL and testbench
=================================

FCLASS_ARBITER -- requirements
Module: fclass_arbiter

Interface
REQ-001 The module SHALL have parameter exp_width, default 8, meaning operand exponent width.
REQ-002 The module SHALL have parameter mant_width, default 24, meaning operand mantissa width including hidden bit (operand width W = exp_width+mant_width).
REQ-003 The module SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The module SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-007 The module SHALL have port req_data, input, NUM_REQ*W bits: requester i operand in slice [i*W +: W].
REQ-008 The module SHALL have port req_ready, output, NUM_REQ bits: one-hot grant/accept, at most one bit set per cycle.
REQ-009 The module SHALL have port rsp_valid, output, 1 bit: classification result valid.
REQ-010 The module SHALL have port rsp_ready, input, 1 bit: consumer accepts result.
REQ-011 The module SHALL have port rsp_id, output, $clog2(NUM_REQ) bits: index of requester owning the result.
REQ-012 The module SHALL have port rsp_result, output, 32 bits: {22'b0, 10-bit class mask}.
REQ-013 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EVAL, RESP.
REQ-015 In IDLE, with any req_valid bit high, the arbiter SHALL combinationally set req_ready for exactly one winner; on that edge it SHALL capture the winner's operand and index and move to EVAL.
REQ-016 req_ready SHALL be all-zero outside IDLE and whenever req_valid is all-zero.
REQ-017 In EVAL, the shared classifier SHALL evaluate the captured operand; the 10-bit mask SHALL be registered into rsp_result, rsp_valid set, state RESP.
REQ-018 Class mask bits SHALL be RISC-V fclass: 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN; exactly one bit set.
REQ-019 Latency SHALL be: accept at edge N, rsp_valid high from cycle N+2; minimum spacing between accepts is 3 cycles.
REQ-020 In RESP, rsp_valid, rsp_id, rsp_result SHALL hold stable until rsp_valid&&rsp_ready; on that edge rsp_valid SHALL clear and state SHALL return to IDLE.
REQ-021 A request arriving or deasserting while not in IDLE SHALL be ignored (not accepted, not lost state); requesters hold req_valid until granted.
REQ-022 rsp_result bits [31:10] SHALL always be zero.

Reset
REQ-023 On rst high at an edge: state IDLE, rsp_valid 0, rsp_result 0, rsp_id 0, busy 0, round-robin pointer NUM_REQ-1 (requester 0 highest priority first).
REQ-024 rst asserted mid-operation (EVAL or RESP) SHALL discard the in-flight operand and result with no response issued; req_ready SHALL be 0 during reset cycles.

Configuration
REQ-025 With macro FCLASS_ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at pointer+1 modulo NUM_REQ, pointer updated to winner on each accept.
REQ-026 Without FCLASS_ARB_RR_EN, arbitration SHALL be fixed priority, lowest index wins, and no pointer register exists.

Verification
REQ-027 Single request: req_valid=0001, req_data[0]=0x7F800000 -> req_ready=0001 at accept cycle N; rsp_valid at N+2, rsp_id=0, rsp_result=0x00000080.
REQ-028 Class coverage: operands 0xFF800000, 0x7FC00000, 0x7F800001, 0x00000000, 0x80000000, 0x00000001 -> results 0x001, 0x200, 0x100, 0x010, 0x008, 0x020.
REQ-029 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable, busy=1, req_ready=0 throughout; rsp_ready=1 -> rsp_valid clears next edge, new accept possible next cycle.
REQ-030 Contention, FCLASS_ARB_RR_EN defined, req_valid=1111 held -> grant order 0,1,2,3,0; undefined -> grants 0,0,0 (until requester 0 drops).
REQ-031 Reset mid-flight: assert rst in EVAL -> next cycle rsp_valid=0, busy=0, no response for that operand; first grant after reset goes to requester 0.

Source files
------------

// File: rtl/fclass_arbiter.sv
// fclass_arbiter: shares one RISC-V fclass classifier among NUM_REQ requesters (IDLE -> EVAL -> RESP).
// Define FCLASS_ARB_RR_EN for round-robin arbitration; the default build is fixed priority (lowest index wins).
module fclass_arbiter #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24,
  parameter int NUM_REQ    = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_valid,
  input  logic [NUM_REQ*(exp_width+mant_width)-1:0] req_data,
  output logic [NUM_REQ-1:0]                        req_ready,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]                rsp_id,
  output logic [31:0]                               rsp_result,
  output logic                                      busy,
  output logic [1:0]                                state_dbg
);
  localparam int W  = exp_width + mant_width;
  localparam int FW = mant_width - 1;
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Handshakes: requester i transfers its operand on a rising edge with req_valid[i] && req_ready[i]
  // (req_ready is the one-hot grant, only raised in IDLE); the result transfers on rsp_valid && rsp_ready,
  // and rsp_valid/rsp_id/rsp_result hold stable until that edge.
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  op_q, op_d;
  logic [IW-1:0] id_q, id_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [9:0]    mask_q, mask_d;

  logic [W-1:0]  req_ops [NUM_REQ];
  logic [IW-1:0] win_idx;
  logic          win_found;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign req_ops[g] = req_data[g*W +: W];
  end

`ifdef FCLASS_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin : arb_rr
    int c;
    logic [IW-1:0] cidx;
    c         = 0;
    cidx      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c    = (int'(ptr_q) + k) % NUM_REQ;
      cidx = c[IW-1:0];
      if (!win_found && req_valid[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
  end

  assign ptr_d = (state_q == IDLE && win_found) ? win_idx : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IW'(NUM_REQ - 1);
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin : arb_fixed
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = i[IW-1:0];
      end
    end
  end
`endif

  function automatic logic [9:0] classify(input logic [W-1:0] op);
    logic                 sign;
    logic [exp_width-1:0] e;
    logic [FW-1:0]        f;
    logic [9:0]           m;
    sign = op[W-1];
    e    = op[W-2 -: exp_width];
    f    = op[FW-1:0];
    m    = '0;
    if (&e) begin
      if (f == '0)      m = sign ? 10'h001 : 10'h080;
      else if (f[FW-1]) m = 10'h200;
      else              m = 10'h100;
    end else if (e == '0) begin
      if (f == '0) m = sign ? 10'h008 : 10'h010;
      else         m = sign ? 10'h004 : 10'h020;
    end else begin
      m = sign ? 10'h002 : 10'h040;
    end
    return m;
  endfunction

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst && win_found) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    mask_d      = mask_q;
    case (state_q)
      IDLE: if (win_found) begin
        op_d    = req_ops[win_idx];
        id_d    = win_idx;
        state_d = EVAL;
      end
      EVAL: begin
        mask_d      = classify(op_q);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      mask_q      <= mask_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = {22'b0, mask_q};
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_fclass_arbiter.sv
// Bench for fclass_arbiter at default parameters: classification table, backpressure, contention,
// reset mid-flight and randomized traffic against a field-arithmetic reference model.
module tb_fclass_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        busy;
  logic [1:0]  state_dbg;

  fclass_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int model_ptr = 3;
  logic [31:0] ops [4];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference classifier built from float fields with plain arithmetic.
  function automatic logic [31:0] model_class(input logic [31:0] op);
    int s, e, f, bitn;
    s = int'(op >> 31);
    e = int'((op >> 23) & 32'hFF);
    f = int'(op & 32'h7FFFFF);
    if (e == 255)    bitn = (f == 0) ? (s ? 0 : 7) : ((f >= 32'h400000) ? 9 : 8);
    else if (e == 0) bitn = (f == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
    else             bitn = s ? 1 : 6;
    return 32'd1 << bitn;
  endfunction

  function automatic logic [1:0] model_pick(input logic [3:0] vld);
    int  w;
    bit  found;
    w = 0;
    found = 0;
`ifdef FCLASS_ARB_RR_EN
    for (int k = 1; k <= 4; k++) begin
      if (!found && ((vld >> ((model_ptr + k) % 4)) & 4'd1) != 0) begin
        w = (model_ptr + k) % 4;
        found = 1;
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (!found && ((vld >> k) & 4'd1) != 0) begin
        w = k;
        found = 1;
      end
    end
`endif
    model_ptr = w;
    return w[1:0];
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] s, e, f;
    s = 32'($urandom_range(0, 1));
    f = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & 32'h7FFFFF);
    case ($urandom_range(0, 3))
      0:       e = 32'd0;
      1:       e = 32'd255;
      default: e = 32'($urandom_range(1, 254));
    endcase
    return (s << 31) | (e << 23) | f;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rst_ready0", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'h0;
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_result", rsp_result, 32'd0);
    model_ptr = 3;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the result is drained.
  task automatic txn(input logic [3:0] vld, input int stall, output logic [1:0] got_id,
                     output logic [31:0] got_res);
    logic [1:0]  w;
    logic [3:0]  oh;
    logic [31:0] er;
    w  = model_pick(vld);
    oh = 4'b0001 << w;
    exp_q.push_back(model_class(ops[w]));
    req_valid = vld;
    req_data  = {ops[3], ops[2], ops[1], ops[0]};
    rsp_ready = 1'b0;
    #1;
    check("grant", 32'(req_ready), 32'(oh));
    @(negedge clk);
    req_data = ~req_data;
    #1;
    check("eval_ready0", 32'(req_ready), 32'd0);
    check("eval_busy", 32'(busy), 32'd1);
    check("eval_novalid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    er = exp_q.pop_front();
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(w));
    check("rsp_result", rsp_result, er);
    got_id  = rsp_id;
    got_res = rsp_result;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_id", 32'(rsp_id), 32'(w));
      check("hold_result", rsp_result, er);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_ready0", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("drain_valid", 32'(rsp_valid), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  gid;
    logic [31:0] gres;
    int          exp_order [5];

    tbl[0] = '{32'h7F800000, 32'h080};
    tbl[1] = '{32'hFF800000, 32'h001};
    tbl[2] = '{32'h7FC00000, 32'h200};
    tbl[3] = '{32'h7F800001, 32'h100};
    tbl[4] = '{32'h00000000, 32'h010};
    tbl[5] = '{32'h80000000, 32'h008};
    tbl[6] = '{32'h00000001, 32'h020};
    tbl[7] = '{32'h3F800000, 32'h040};
    tbl[8] = '{32'hBF800000, 32'h002};
    tbl[9] = '{32'h80000001, 32'h004};
`ifdef FCLASS_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    for (int j = 0; j < 4; j++) ops[j] = 32'h0;
    rst = 1'b1;
    req_valid = 4'h0;
    req_data = '0;
    rsp_ready = 1'b0;
    do_reset();

    // Table: single requester per vector; the first one also exercises 5 cycles of backpressure.
    for (int i = 0; i < 10; i++) begin
      ops[i % 4] = tbl[i].op;
      txn(4'b0001 << (i % 4), (i == 0) ? 5 : 0, gid, gres);
      check("table_result", gres, tbl[i].res);
      check("table_id", 32'(gid), 32'(i % 4));
    end

    // Contention with all requesters held valid.
    do_reset();
    for (int j = 0; j < 4; j++) ops[j] = tbl[j].op;
    for (int k = 0; k < 5; k++) begin
      txn(4'b1111, 0, gid, gres);
      check("cont_order", 32'(gid), 32'(exp_order[k]));
    end

    // Reset while the operand is in EVAL: nothing is reported, requester 0 wins first afterwards.
    ops[2] = 32'h7F800000;
    req_valid = 4'b0100;
    req_data  = {ops[3], ops[2], ops[1], ops[0]};
    #1;
    check("mf_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    check("mf_rst_ready0", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("mf_valid", 32'(rsp_valid), 32'd0);
    check("mf_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    req_valid = 4'h0;
    model_ptr = 3;
    @(negedge clk);
    check("mf_noresp", 32'(rsp_valid), 32'd0);
    check("mf_idle", 32'(busy), 32'd0);
    txn(4'b1111, 0, gid, gres);
    check("mf_first_grant", 32'(gid), 32'd0);

    // Randomized traffic.
    for (int r = 0; r < 60; r++) begin
      for (int j = 0; j < 4; j++) ops[j] = rand_op();
      txn(4'($urandom_range(1, 15)), $urandom_range(0, 2), gid, gres);
    end

    req_valid = 4'h0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
